adsr_envelope: RTL

- Amplitude-envelope stage between the waveform combiner and the PWM output stage.
- Consumes the combined 9-bit sample and its ready strobe, and tracks a key gate through attack/decay/sustain/release.
- Emits the sample scaled by the current envelope level, with its own ready strobe, to the PWM stage.
- Envelope advances on the shared sample-rate tick (the same pulse that drives the soundpaths).

---
 rtl/sass_pkg.sv | 23 ++
 rtl/env_step.sv | 46 ++++
 rtl/adsr_envelope.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sass_pkg.sv
// Shared definitions for the amplitude-envelope stage.
//   env_state_t : envelope phase encoding (3-bit, also exported as a debug port)
//   ENV_W_DEF   : default envelope level width
//   ENV_MAX     : full-scale envelope level for the default width
//   *_DEF       : default per-tick step sizes and sustain level
package sass_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int ENV_W_DEF         = 8;
  localparam int ENV_MAX           = (1 << ENV_W_DEF) - 1;
  localparam int ATTACK_STEP_DEF   = 16;
  localparam int DECAY_STEP_DEF    = 4;
  localparam int SUSTAIN_LEVEL_DEF = 192;
  localparam int RELEASE_STEP_DEF  = 8;

endpackage

// File: rtl/env_step.sv
// Saturating envelope stepper (purely combinational).
//   level      : current envelope level
//   step       : amount to add (up) or subtract (down)
//   limit      : ceiling when counting up, floor when counting down
//   up         : 1 = add toward ceiling, 0 = subtract toward floor
//   next_level : stepped level, clamped to limit
//   hit        : next_level landed on limit
module env_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] level,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  input  logic         up,
  output logic [W-1:0] next_level,
  output logic         hit
);

  // One extra bit catches carry out on add and borrow on subtract.
  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, level} + {1'b0, step};
  assign diff = {1'b0, level} - {1'b0, step};

  always_comb begin
    next_level = level;
    hit        = 1'b0;
    if (up) begin
      if (sum >= {1'b0, limit}) begin
        next_level = limit;
        hit        = 1'b1;
      end else begin
        next_level = sum[W-1:0];
      end
    end else begin
      if (diff[W] || (diff[W-1:0] <= limit)) begin
        next_level = limit;
        hit        = 1'b1;
      end else begin
        next_level = diff[W-1:0];
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope between the waveform combiner and the PWM stage.
//   clk        : system clock
//   n_rst      : asynchronous active-low reset
//   sample_now : one-cycle sample-rate tick, steps the envelope
//   gate       : note active; rising edge starts attack, falling edge releases
//   ready_in   : one-cycle strobe, sample_in valid
//   sample_in  : unsigned combined waveform
//   ready_out  : one-cycle strobe, sample_out updated (one cycle after ready_in)
//   sample_out : sample_in scaled by the envelope level
//   env_level  : current envelope level
//   env_state  : current envelope phase
module adsr_envelope
  import sass_pkg::*;
#(
  parameter int SAMPLE_W      = 9,
  parameter int ENV_W         = ENV_W_DEF,
  parameter int ATTACK_STEP   = ATTACK_STEP_DEF,
  parameter int DECAY_STEP    = DECAY_STEP_DEF,
  parameter int SUSTAIN_LEVEL = SUSTAIN_LEVEL_DEF,
  parameter int RELEASE_STEP  = RELEASE_STEP_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sample_now,
  input  logic                gate,
  input  logic                ready_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                ready_out,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic [ENV_W-1:0]    env_level,
  output logic [2:0]          env_state
);

  localparam int PROD_W = SAMPLE_W + ENV_W;

  localparam logic [ENV_W-1:0] ENV_TOP = {ENV_W{1'b1}};
  localparam logic [ENV_W-1:0] A_STEP  = ENV_W'(ATTACK_STEP);
  localparam logic [ENV_W-1:0] D_STEP  = ENV_W'(DECAY_STEP);
  localparam logic [ENV_W-1:0] R_STEP  = ENV_W'(RELEASE_STEP);
  localparam logic [ENV_W-1:0] S_LEVEL = ENV_W'(SUSTAIN_LEVEL);

  // Full scale passes the sample through untouched; otherwise keep the
  // top SAMPLE_W bits of the product (i.e. >> ENV_W, truncated).
  function automatic logic [SAMPLE_W-1:0] scale_sample(
    input logic [SAMPLE_W-1:0] s,
    input logic [ENV_W-1:0]    lvl
  );
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'(lvl);
    if (lvl == ENV_TOP) return s;
    return prod[ENV_W +: SAMPLE_W];
  endfunction

  env_state_t          state_q, state_n;
  logic [ENV_W-1:0]    level_q, level_n;
  logic                gate_q;
  logic                rise, fall;

  logic [ENV_W-1:0]    step_op, limit_op, step_next;
  logic                step_up, step_hit;

  logic [SAMPLE_W-1:0] sample_p1;
  logic                vld_p1;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // Stepper operands chosen by the current phase.
  always_comb begin
    step_op  = '0;
    limit_op = '0;
    step_up  = 1'b0;
    unique case (state_q)
      ATTACK: begin
        step_op  = A_STEP;
        limit_op = ENV_TOP;
        step_up  = 1'b1;
      end
      DECAY: begin
        step_op  = D_STEP;
        limit_op = S_LEVEL;
      end
      RELEASE: begin
        step_op  = R_STEP;
        limit_op = '0;
      end
      default: ;
    endcase
  end

  env_step #(
    .W(ENV_W)
  ) u_env_step (
    .level      (level_q),
    .step       (step_op),
    .limit      (limit_op),
    .up         (step_up),
    .next_level (step_next),
    .hit        (step_hit)
  );

  // Gate edges take priority over the tick; the level is frozen on an edge.
  always_comb begin
    state_n = state_q;
    level_n = level_q;
    if (rise) begin
      state_n = ATTACK;
    end else if (fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
      state_n = RELEASE;
    end else if (sample_now) begin
      unique case (state_q)
        ATTACK: begin
          level_n = step_next;
          if (step_hit) state_n = DECAY;
        end
        DECAY: begin
          level_n = step_next;
          if (step_hit) state_n = SUSTAIN;
        end
        SUSTAIN: level_n = S_LEVEL;
        RELEASE: begin
          level_n = step_next;
          if (step_hit) state_n = IDLE;
        end
        default: level_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      level_q <= level_n;
      gate_q  <= gate;
    end
  end

  // ---- stage p1: scaled sample register, uses the level of the strobe cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= ready_in;
      if (ready_in) sample_p1 <= scale_sample(sample_in, level_q);
    end
  end

  assign ready_out  = vld_p1;
  assign sample_out = sample_p1;
  assign env_level  = level_q;
  assign env_state  = state_q;

endmodule
